// File: rtl/npu_cmd_serializer_pkg.sv
// Shared widths, default FIFO depth and serializer FSM encoding for npu_cmd_serializer.
package npu_cmd_serializer_pkg;

    localparam int unsigned CmdW         = 32;
    localparam int unsigned AxisW        = 16;
    localparam int unsigned DefFifoDepth = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSendHi = 2'd1,
        StSendLo = 2'd2
    } ser_state_e;

endpackage

// File: rtl/npu_cmd_serializer_fifo.sv
// Synchronous command FIFO (npu_sync_fifo) with registered occupancy and synchronous flush.
module npu_sync_fifo #(
    parameter int unsigned Width = 33,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [Width-1:0]           rdata_o,
    output logic [$clog2(Depth):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned LvlW = $clog2(Depth) + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LvlW'(Depth));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                level_d = level_q + LvlW'(1);
            end else if (do_pop && !do_push) begin
                level_d = level_q - LvlW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/npu_cmd_serializer.sv
// Splits FIFO-buffered host command words into two AXI-Stream beats (high half first).
module npu_cmd_serializer
    import npu_cmd_serializer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DefFifoDepth,
    parameter int unsigned CMD_W      = CmdW,
    parameter int unsigned AXIS_W     = AxisW
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CMD_W-1:0]              cmd_data,
    input  logic                          cmd_valid,
    input  logic                          cmd_last,
    output logic                          cmd_ready,
    input  logic                          flush,
    output logic [AXIS_W-1:0]             m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   pkt_count,
    output logic                          busy
);

    logic             fifo_pop, fifo_full, fifo_empty;
    logic [CMD_W:0]   fifo_rdata;
    ser_state_e       state_q, state_d;
    logic [CMD_W:0]   hold_q, hold_d;
    logic [15:0]      pkt_count_q, pkt_count_d;

    npu_sync_fifo #(
        .Width (CMD_W + 1),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (cmd_valid),
        .wdata_i ({cmd_last, cmd_data}),
        .pop_i   (fifo_pop),
        .flush_i (flush),
        .rdata_o (fifo_rdata),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_q != StIdle);
    assign pkt_count = pkt_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // The pop that ends SEND_LO reloads the holding register so beats stream without a bubble.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = StSendHi;
                end
            end
            StSendHi: begin
                if (m_axis_tready) begin
                    state_d = StSendLo;
                end
            end
            StSendLo: begin
                if (m_axis_tready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = StSendHi;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d  = StIdle;
            fifo_pop = 1'b0;
        end
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        unique case (state_q)
            StSendHi: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hold_q[CMD_W-1:AXIS_W];
            end
            StSendLo: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hold_q[AXIS_W-1:0];
                m_axis_tlast  = hold_q[CMD_W];
            end
            default: ;
        endcase
    end

    always_comb begin
        hold_d      = fifo_pop ? fifo_rdata : hold_q;
        pkt_count_d = pkt_count_q;
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast && !flush) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            pkt_count_q <= '0;
        end else begin
            hold_q      <= hold_d;
            pkt_count_q <= pkt_count_d;
        end
    end

endmodule
